// File: rtl/data_mem_ctrl.sv
// Load/store sequencer for a one-cycle-latency synchronous data memory.
// Define MISALIGN_SPLIT_EN to split word-straddling accesses; otherwise they fault.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [2:0]        Lw_Sw_OP,
  input  logic [31:0]       Req_Addr,
  input  logic [31:0]       Req_Wdata,
  output logic              Resp_Valid,
  output logic [31:0]       Resp_Rdata,
  output logic              Access_Fault,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [3:0]        Mem_Byte_En,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  input  logic [31:0]       Mem_Rdata
);

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT_RD, RESP} state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic                write_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                fault_q;
  logic [31:0]         lo_q, hi_q;

  logic [7:0]          req_mask, mask;
  logic                req_split, req_bad, split;
  logic [1:0]          off;
  logic [63:0]         st_data;
  logic [31:0]         ld_word;
  logic [ADDR_W-1:0]   word0;
  logic                unused_addr;

  // Byte footprint of an access before lane shifting
  function automatic logic [7:0] size_mask(input logic [2:0] op);
    case (op)
      3'd0, 3'd3: size_mask = 8'h01;
      3'd1, 3'd4: size_mask = 8'h03;
      default:    size_mask = 8'h0F;
    endcase
  endfunction

  assign req_mask    = 8'(size_mask(Lw_Sw_OP) << Req_Addr[1:0]);
  assign req_split   = |req_mask[7:4];
  assign req_bad     = (Lw_Sw_OP > 3'd4)
                     || (Req_Write && (Lw_Sw_OP == 3'd3 || Lw_Sw_OP == 3'd4))
                     || (!SPLIT_EN && req_split);
  assign unused_addr = ^Req_Addr[31:ADDR_W+2];

  assign off     = addr_q[1:0];
  assign mask    = 8'(size_mask(op_q) << off);
  assign split   = |mask[7:4];
  assign st_data = {32'd0, wdata_q} << {off, 3'b000};
  assign ld_word = 32'({hi_q, lo_q} >> {off, 3'b000});
  assign word0   = addr_q[ADDR_W+1:2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch and read-word capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q    <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (state == IDLE && Req_Valid) begin
        op_q    <= Lw_Sw_OP;
        write_q <= Req_Write;
        addr_q  <= Req_Addr[ADDR_W+1:0];
        wdata_q <= Req_Wdata;
        fault_q <= req_bad;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state == ACC1 && !write_q) lo_q <= Mem_Rdata;
      if (state == WAIT_RD) begin
        if (split) hi_q <= Mem_Rdata;
        else       lo_q <= Mem_Rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    Req_Ready    = 1'b0;
    Resp_Valid   = 1'b0;
    Resp_Rdata   = '0;
    Access_Fault = 1'b0;
    Mem_En       = 1'b0;
    Mem_We       = 1'b0;
    Mem_Byte_En  = '0;
    Mem_Addr     = '0;
    Mem_Wdata    = '0;
    case (state)
      IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) state_nxt = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        Mem_En   = 1'b1;
        Mem_We   = write_q;
        Mem_Addr = word0;
        if (write_q) begin
          Mem_Byte_En = mask[3:0];
          Mem_Wdata   = st_data[31:0];
        end
        if (split && SPLIT_EN) state_nxt = ACC1;
        else                   state_nxt = write_q ? RESP : WAIT_RD;
      end
      ACC1: begin
        Mem_En   = 1'b1;
        Mem_We   = write_q;
        Mem_Addr = word0 + ADDR_W'(1);
        if (write_q) begin
          Mem_Byte_En = mask[7:4];
          Mem_Wdata   = st_data[63:32];
        end
        state_nxt = write_q ? RESP : WAIT_RD;
      end
      WAIT_RD: state_nxt = RESP;
      RESP: begin
        Resp_Valid   = 1'b1;
        Access_Fault = fault_q;
        if (!fault_q && !write_q) begin
          case (op_q)
            3'd0:    Resp_Rdata = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    Resp_Rdata = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd3:    Resp_Rdata = {24'd0, ld_word[7:0]};
            3'd4:    Resp_Rdata = {16'd0, ld_word[15:0]};
            default: Resp_Rdata = ld_word;
          endcase
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a 1-cycle-latency memory model.
module tb_data_mem_ctrl;
  localparam int unsigned ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Req_Valid, Req_Ready, Req_Write;
  logic [2:0]        Lw_Sw_OP;
  logic [31:0]       Req_Addr, Req_Wdata;
  logic              Resp_Valid, Access_Fault;
  logic [31:0]       Resp_Rdata;
  logic              Mem_En, Mem_We;
  logic [3:0]        Mem_Byte_En;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_Wdata, Mem_Rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  int          lat, n_acc;
  logic [31:0] rd;
  logic        flt;
  logic [31:0] acc_addr [0:1];
  logic [3:0]  acc_be   [0:1];
  logic [31:0] acc_wd   [0:1];
  logic        acc_we   [0:1];

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Lw_Sw_OP(Lw_Sw_OP), .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata),
    .Resp_Valid(Resp_Valid), .Resp_Rdata(Resp_Rdata), .Access_Fault(Access_Fault),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Byte_En(Mem_Byte_En),
    .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read memory with byte write enables
  always @(posedge Clk) begin
    if (Mem_En) begin
      if (Mem_We)
        for (int b = 0; b < 4; b++)
          if (Mem_Byte_En[b]) mem[Mem_Addr][8*b +: 8] <= Mem_Wdata[8*b +: 8];
      Mem_Rdata <= mem[Mem_Addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Write = wr; Lw_Sw_OP = op; Req_Addr = addr; Req_Wdata = wd;
    @(posedge Clk);
    #1 Req_Valid = 1'b0;
    lat = 0; n_acc = 0; rd = '0; flt = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (Mem_En) begin
        if (n_acc < 2) begin
          acc_addr[n_acc] = 32'(Mem_Addr);
          acc_be[n_acc]   = Mem_Byte_En;
          acc_wd[n_acc]   = Mem_Wdata;
          acc_we[n_acc]   = Mem_We;
        end
        n_acc++;
      end
      if (Resp_Valid) begin
        lat = k; rd = Resp_Rdata; flt = Access_Fault;
        break;
      end
    end
    if (lat == 0) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] exp_d, input int exp_lat);
    do_req(1'b0, op, addr, 32'd0);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, rd, exp_d);
    check_eq({tag, "_fault"}, 32'(flt), 32'd0);
  endtask

  task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int exp_lat);
    do_req(1'b1, op, addr, wd);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rdata"}, rd, 32'd0);
    check_eq({tag, "_fault"}, 32'(flt), 32'd0);
  endtask

  task automatic fault_chk(input string tag, input logic wr, input logic [2:0] op,
                           input logic [31:0] addr);
    do_req(wr, op, addr, 32'hFFFF_FFFF);
    check_eq({tag, "_lat"}, 32'(lat), 32'd1);
    check_eq({tag, "_fault"}, 32'(flt), 32'd1);
    check_eq({tag, "_rdata"}, rd, 32'd0);
    check_eq({tag, "_nacc"}, 32'(n_acc), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    Mem_Rdata = '0;
    Reset = 1'b1; Req_Valid = 1'b1; Req_Write = 1'b1; Lw_Sw_OP = 3'd2;
    Req_Addr = 32'h100; Req_Wdata = 32'h1234_5678;
    repeat (3) @(negedge Clk);
    check_eq("rst_ready", 32'(Req_Ready), 32'd1);
    check_eq("rst_mem_en", 32'(Mem_En), 32'd0);
    check_eq("rst_resp", 32'(Resp_Valid), 32'd0);
    check_eq("rst_fault", 32'(Access_Fault), 32'd0);
    check_eq("rst_addr", 32'(Mem_Addr), 32'd0);
    check_eq("rst_rdata", Resp_Rdata, 32'd0);
    Req_Valid = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);

    // Aligned word store then load
    store_chk("sw_100", 3'd2, 32'h100, 32'hDEAD_BEEF, 2);
    check_eq("sw_100_nacc", 32'(n_acc), 32'd1);
    check_eq("sw_100_addr", acc_addr[0], 32'h40);
    check_eq("sw_100_be", 32'(acc_be[0]), 32'hF);
    check_eq("sw_100_wd", acc_wd[0], 32'hDEAD_BEEF);
    check_eq("sw_100_we", 32'(acc_we[0]), 32'd1);
    load_chk("lw_100", 3'd2, 32'h100, 32'hDEAD_BEEF, 3);
    check_eq("lw_100_addr", acc_addr[0], 32'h40);
    check_eq("lw_100_be", 32'(acc_be[0]), 32'h0);
    check_eq("lw_100_we", 32'(acc_we[0]), 32'd0);

    // Byte/half extension
    store_chk("sw_200", 3'd2, 32'h200, 32'h80FF_7F01, 2);
    load_chk("lb_203", 3'd0, 32'h203, 32'hFFFF_FF80, 3);
    load_chk("lbu_203", 3'd3, 32'h203, 32'h0000_0080, 3);
    load_chk("lb_200", 3'd0, 32'h200, 32'h0000_0001, 3);
    load_chk("lb_201", 3'd0, 32'h201, 32'h0000_007F, 3);
    load_chk("lh_202", 3'd1, 32'h202, 32'hFFFF_80FF, 3);
    load_chk("lhu_202", 3'd4, 32'h202, 32'h0000_80FF, 3);
    load_chk("lh_200", 3'd1, 32'h200, 32'h0000_7F01, 3);

    // Sub-word stores land in the right lane
    store_chk("sb_102", 3'd0, 32'h102, 32'h0000_0055, 2);
    check_eq("sb_102_be", 32'(acc_be[0]), 32'h4);
    check_eq("sb_102_wd", acc_wd[0], 32'h0055_0000);
    load_chk("lw_100b", 3'd2, 32'h100, 32'hDE55_BEEF, 3);

    store_chk("sw_10", 3'd2, 32'h10, 32'h4433_2211, 2);
    store_chk("sw_14", 3'd2, 32'h14, 32'h8877_6655, 2);

`ifdef MISALIGN_SPLIT_EN
    load_chk("lw_13", 3'd2, 32'h13, 32'h7766_5544, 4);
    check_eq("lw_13_nacc", 32'(n_acc), 32'd2);
    check_eq("lw_13_a0", acc_addr[0], 32'h04);
    check_eq("lw_13_a1", acc_addr[1], 32'h05);
    store_chk("sh_13", 3'd1, 32'h13, 32'h0000_ABCD, 3);
    check_eq("sh_13_be0", 32'(acc_be[0]), 32'h8);
    check_eq("sh_13_wd0", acc_wd[0], 32'hCD00_0000);
    check_eq("sh_13_be1", 32'(acc_be[1]), 32'h1);
    check_eq("sh_13_wd1", acc_wd[1], 32'h0000_00AB);
    load_chk("lw_10", 3'd2, 32'h10, 32'hCD33_2211, 3);
    load_chk("lw_14", 3'd2, 32'h14, 32'h8877_66AB, 3);

    // Top-of-memory wrap
    store_chk("sw_ffc", 3'd2, 32'hFFC, 32'h1122_3344, 2);
    store_chk("sw_000", 3'd2, 32'h000, 32'h5566_7788, 2);
    load_chk("lw_ffd", 3'd2, 32'hFFD, 32'h8811_2233, 4);
    check_eq("lw_ffd_a0", acc_addr[0], 32'h3FF);
    check_eq("lw_ffd_a1", acc_addr[1], 32'h000);

    // Reset while in ACC1
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Write = 1'b0; Lw_Sw_OP = 3'd2; Req_Addr = 32'h13;
    @(posedge Clk);
    #1 Req_Valid = 1'b0;
    @(posedge Clk);
    #1 check_eq("acc1_mem_en", 32'(Mem_En), 32'd1);
    check_eq("acc1_addr", 32'(Mem_Addr), 32'h05);
`else
    fault_chk("lw_13", 1'b0, 3'd2, 32'h13);
    fault_chk("sh_13", 1'b1, 3'd1, 32'h13);
    fault_chk("lw_ffd", 1'b0, 3'd2, 32'hFFD);
    load_chk("lw_10", 3'd2, 32'h10, 32'h4433_2211, 3);

    // Reset while in ACC0
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Write = 1'b0; Lw_Sw_OP = 3'd2; Req_Addr = 32'h100;
    @(posedge Clk);
    #1 Req_Valid = 1'b0;
    check_eq("acc0_mem_en", 32'(Mem_En), 32'd1);
    check_eq("acc0_addr", 32'(Mem_Addr), 32'h40);
`endif
    Reset = 1'b1;
    #1;
    check_eq("midrst_mem_en", 32'(Mem_En), 32'd0);
    check_eq("midrst_ready", 32'(Req_Ready), 32'd1);
    check_eq("midrst_resp", 32'(Resp_Valid), 32'd0);
    check_eq("midrst_addr", 32'(Mem_Addr), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge Clk);
      if (Resp_Valid || Mem_En) seen++;
    end
    check_eq("post_rst_quiet", 32'(seen), 32'd0);

    // Illegal op/direction combinations
    fault_chk("lbu_wr", 1'b1, 3'd3, 32'h200);
    fault_chk("lhu_wr", 1'b1, 3'd4, 32'h200);
    fault_chk("op6", 1'b0, 3'd6, 32'h200);
    fault_chk("op7_wr", 1'b1, 3'd7, 32'h200);
    load_chk("lw_200", 3'd2, 32'h200, 32'h80FF_7F01, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store sequencer between the core's memory stage and a synchronous-read data memory with one-cycle read latency. It accepts one request per handshake and generates word-addressed accesses with byte enables. It splits accesses that straddle a word boundary into two accesses and returns sign- or zero-extended load data with a single response pulse.

Parameters:
ADDR_W, 12, word-address width of the data memory (memory depth = 2^ADDR_W words).

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req_Valid  in  1  core presents a load/store request
Req_Ready  out  1  controller idle; request accepted when Req_Valid & Req_Ready
Req_Write  in  1  1 = store, 0 = load
Lw_Sw_OP  in  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 3 LBU, 4 LHU
Req_Addr  in  32  byte address; bits [ADDR_W+1:0] used
Req_Wdata  in  32  store data, right-justified
Resp_Valid  out  1  one-cycle pulse: load data valid or store complete
Resp_Rdata  out  32  extended load data; 0 for stores and faults
Access_Fault  out  1  pulses with Resp_Valid when the request was rejected
Mem_En  out  1  memory access strobe
Mem_We  out  1  write strobe, qualified by Mem_En
Mem_Byte_En  out  4  per-byte write enables
Mem_Addr  out  ADDR_W  word address
Mem_Wdata  out  32  write data, lane-aligned
Mem_Rdata  in  32  read word, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- States: IDLE, ACC0, ACC1, WAIT_RD, RESP.
- Reset, including mid-operation: state becomes IDLE and all latched request fields clear. Outputs during and after reset: Req_Ready=1; Resp_Valid, Access_Fault, Mem_En, Mem_We = 0; Mem_Byte_En, Mem_Addr, Mem_Wdata, Resp_Rdata = 0. Req_Valid is ignored while Reset is high. An in-flight split store may be left half-written.
- Outputs are decoded from the registered state and latched fields only; there is no combinational path from the Req_* inputs to outputs.
- IDLE (Req_Ready=1): on handshake, latch op, write flag, address, wdata.
  - off = Req_Addr[1:0].
  - 8-bit mask = {SB:0x01, SH:0x03, SW:0x0F} << off.
  - 64-bit wdata = Req_Wdata << (8*off).
  - split = |mask[7:4].
  - Next state ACC0, or RESP with fault.
- Fault condition: op 5..7, or op 3..4 with Req_Write=1. The request is accepted with no memory access; next cycle is RESP with Access_Fault=1 and Resp_Rdata=0.
- ACC0: Mem_En=1, Mem_Addr=word0=Req_Addr[ADDR_W+1:2], Mem_We=Req_Write.
  - Stores: Mem_Byte_En=mask[3:0], Mem_Wdata=wdata[31:0].
  - Next state: ACC1 if split; else WAIT_RD for a load, RESP for a store.
- ACC1: Mem_En=1, Mem_Addr=word0+1 modulo 2^ADDR_W (top word wraps to 0).
  - Stores: Mem_Byte_En=mask[7:4], Mem_Wdata=wdata[63:32].
  - Loads: capture Mem_Rdata as the low word.
  - Next state: WAIT_RD for a load, RESP for a store.
- WAIT_RD: Mem_En=0. Capture Mem_Rdata as the high word if split, else as the low word. Next state RESP.
- RESP: Resp_Valid=1 for one cycle; next state IDLE.
  - Load data = ({hi,lo} >> 8*off)[31:0], then extended per op: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW pass-through.
- Inactive memory outputs: Mem_Byte_En and Mem_Wdata are 0 whenever Mem_We=0. All Mem_* outputs are 0 outside ACC0/ACC1.
- Latency, counted from the handshake cycle T0:
  - aligned store: Resp_Valid at T2
  - split store: Resp_Valid at T3
  - aligned load: Resp_Valid at T3
  - split load: Resp_Valid at T4
  - fault: Resp_Valid at T1
- Throughput: next acceptance no earlier than the cycle after RESP.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: straddling requests are split into two accesses as above.
- Undefined: any request with split=1 is a fault, with no Mem_En and Resp_Valid at T1 with Access_Fault=1. ACC1 is unreachable and may be omitted.

Test Plan:
- Aligned word: SW 0xDEADBEEF @0x100, then LW @0x100 -> write has Mem_Addr=0x40 and Byte_En=0xF; load gives Resp_Rdata=0xDEADBEEF at T3.
- Byte extension: word 0x80FF7F01 @0x200 -> LB @0x203 = 0xFFFFFF80; LBU @0x203 = 0x00000080; LB @0x200 = 0x00000001; LH @0x202 = 0xFFFF80FF; LHU @0x202 = 0x000080FF.
- Split (macro on): word 0x44332211 @0x10 and 0x88776655 @0x14; LW @0x13 -> Mem_Addr 0x04 then 0x05, Resp_Rdata=0x77665544 at T4. SH 0xABCD @0x13 -> Byte_En 0x8 with Wdata 0xCD000000, then Byte_En 0x1 with Wdata 0x000000AB.
- Split (macro off): LW @0x13 -> no Mem_En; Resp_Valid and Access_Fault at T1; Resp_Rdata=0.
- Illegal op: Lw_Sw_OP=3 with Req_Write=1, or Lw_Sw_OP=6 -> Access_Fault pulse at T1, no memory access.
- Wrap and reset: LW @0xFFD (ADDR_W=10) -> Mem_Addr 0x3FF then 0x000. Assert Reset during ACC1 -> next state IDLE, Req_Ready=1, no Resp_Valid, Mem_En=0 immediately.
